unum_mac_array: RTL

- Parametrised successor of the single-lane matrix multiply-accumulator.
- Each beat accepts LANES operand pairs and multiplies them in parallel as signed fixed-point integers (pre-decoded unum fractions).
- Lane products are summed into a wide accumulator. A beat flagged last closes the vector into an output holding register, so the next vector accumulates while the previous result drains.
- Adds valid/ready backpressure, saturating output narrowing, a sticky infinity flag and a beat count.

---
 rtl/unum_mac_array.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/unum_mac_array.sv
// Multi-lane signed multiply-accumulate over vectors of beats, with a holding register
// that drains each finished vector while the next one accumulates.
module unum_mac_array #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 48,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*IN_W-1:0]  op_a,
  input  logic [LANES*IN_W-1:0]  op_b,
  input  logic [LANES-1:0]       op_inf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sum,
  output logic                   out_overflow,
  output logic                   out_inf,
  output logic [CNT_W-1:0]       out_count
);

  localparam int unsigned PROD_W = 2 * IN_W;
  localparam logic [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SatMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [LANES*PROD_W-1:0] prod, s1_prod_q;
  logic                    s1_valid_q, s1_last_q, s1_inf_q;
  logic [ACC_W-1:0]        acc_q, lane_sum, total;
  logic                    inf_acc_q;
  logic [CNT_W-1:0]        cnt_q, cnt_inc;
  logic                    hold_full_q, hold_ovf_q, hold_inf_q;
  logic [OUT_W-1:0]        hold_sum_q;
  logic [CNT_W-1:0]        hold_cnt_q;

  logic             stall, advance, load_hold, vec_inf, over_hi, over_lo;
  logic [OUT_W-1:0] sum_d;
  logic             ovf_d;

  // Operands are sign-extended to the product width so the multiply is exact.
  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i*PROD_W +: PROD_W] =
          $signed({{IN_W{op_a[i*IN_W+IN_W-1]}}, op_a[i*IN_W +: IN_W]}) *
          $signed({{IN_W{op_b[i*IN_W+IN_W-1]}}, op_b[i*IN_W +: IN_W]});
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(ACC_W-PROD_W){s1_prod_q[i*PROD_W+PROD_W-1]}},
                             s1_prod_q[i*PROD_W +: PROD_W]};
    end
  end

  assign total   = acc_q + lane_sum;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign vec_inf = inf_acc_q | s1_inf_q;
  assign over_hi = $signed(total) > $signed(SatMax);
  assign over_lo = $signed(total) < $signed(SatMin);

  always_comb begin
    sum_d = total[OUT_W-1:0];
    ovf_d = 1'b0;
    if (vec_inf) begin
      sum_d = '0;
    end else if (over_hi) begin
      sum_d = {1'b0, {(OUT_W-1){1'b1}}};
      ovf_d = 1'b1;
    end else if (over_lo) begin
      sum_d = {1'b1, {(OUT_W-1){1'b0}}};
      ovf_d = 1'b1;
    end
  end

  // A closing beat cannot retire while the previous result is still unclaimed.
  assign stall     = s1_valid_q && s1_last_q && hold_full_q && !out_ready;
  assign in_ready  = !stall;
  assign advance   = s1_valid_q && !stall && !clr;
  assign load_hold = advance && s1_last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_prod_q   <= '0;
      acc_q       <= '0;
      inf_acc_q   <= 1'b0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      hold_sum_q  <= '0;
      hold_ovf_q  <= 1'b0;
      hold_inf_q  <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      if (clr) begin
        s1_valid_q <= 1'b0;
      end else if (!stall) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_prod_q <= prod;
          s1_inf_q  <= |op_inf;
          s1_last_q <= in_last;
        end
      end

      if (clr) begin
        acc_q     <= '0;
        inf_acc_q <= 1'b0;
        cnt_q     <= '0;
      end else if (advance) begin
        if (s1_last_q) begin
          acc_q     <= '0;
          inf_acc_q <= 1'b0;
          cnt_q     <= '0;
        end else begin
          acc_q     <= total;
          inf_acc_q <= vec_inf;
          cnt_q     <= cnt_inc;
        end
      end

      if (load_hold) begin
        hold_full_q <= 1'b1;
        hold_sum_q  <= sum_d;
        hold_ovf_q  <= ovf_d;
        hold_inf_q  <= vec_inf;
        hold_cnt_q  <= cnt_inc;
      end else if (hold_full_q && out_ready) begin
        hold_full_q <= 1'b0;
        hold_sum_q  <= '0;
        hold_ovf_q  <= 1'b0;
        hold_inf_q  <= 1'b0;
        hold_cnt_q  <= '0;
      end
    end
  end

  assign out_valid    = hold_full_q;
  assign out_sum      = hold_sum_q;
  assign out_overflow = hold_ovf_q;
  assign out_inf      = hold_inf_q;
  assign out_count    = hold_cnt_q;

endmodule
